writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, default 2, number of writeback requesters.
- REG_WIDTH, default 32, data width.
- NUM_REGS, default 32, register count.
- ADDR_WIDTH, default $clog2(NUM_REGS), register address width.
- SKIP_ZERO, default 0; when 1, writes to address 0 are accepted but never issued.
- CNT_WIDTH, default 16, conflict counter width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wb_hold  in  1  suspends all grants while high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened destination addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*REG_WIDTH  flattened write data; requester i occupies bits [i*REG_WIDTH +: REG_WIDTH].
- req_ready  out  NUM_REQ  one-hot-or-zero grant; a request is accepted at a rising edge where valid and ready are both high.
- write_enable  out  1  register-file write strobe.
- write_addr  out  ADDR_WIDTH  register-file write address.
- write_data  out  REG_WIDTH  register-file write data.
- grant_id  out  $clog2(NUM_REQ) (min 1)  index of the requester whose write is on the port.
- conflict_count  out  CNT_WIDTH  saturating count of contended cycles.

Function
REQ-003 req_ready SHALL be combinational from req_valid, wb_hold and the priority pointer, with at most one bit high.
REQ-004 req_ready SHALL be all-zero while wb_hold is 1.
REQ-005 Arbitration SHALL be round-robin: search starts at pointer ptr, ascending with wrap modulo NUM_REQ; the first valid requester found is granted.
REQ-006 On acceptance from requester g, ptr SHALL become (g+1) mod NUM_REQ at that edge; ptr SHALL be unchanged in cycles with no acceptance.
REQ-007 An acceptance at edge N SHALL drive write_enable=1, write_addr/write_data=the accepted request and grant_id=g during cycle N+1 (registered, 1-cycle latency).
REQ-008 write_enable SHALL be 1 for exactly one cycle per accepted request; back-to-back acceptances SHALL give consecutive write pulses, sustaining 1 write/cycle.
REQ-009 When no acceptance occurs at an edge, write_enable SHALL be 0 in the following cycle; write_addr, write_data and grant_id SHALL hold their previous values.
REQ-010 With SKIP_ZERO=1, an accepted request with address 0 SHALL advance ptr and update write_addr, write_data and grant_id, but SHALL leave write_enable 0.
REQ-011 With SKIP_ZERO=0, address 0 SHALL be issued normally.
REQ-012 Requesters SHALL hold valid, addr and data stable until accepted; the block SHALL NOT buffer more than the single output stage.
REQ-013 conflict_count SHALL increment by 1 at each edge where wb_hold=0 and two or more req_valid bits are high.
REQ-014 conflict_count SHALL saturate at all-ones and never wrap.
REQ-015 A wb_hold assertion SHALL NOT cancel a write already registered in the output stage; that write completes in its cycle.
REQ-016 With NUM_REQ=1, the block SHALL reduce to a registered pass-through with ready = valid & ~wb_hold.

Reset
REQ-017 While rst_n=0, the following SHALL be forced immediately, independent of clk: write_enable=0, write_addr=0, write_data=0, grant_id=0, ptr=0, conflict_count=0.
REQ-018 req_ready SHALL be all-zero while rst_n=0.
REQ-019 Reset asserted mid-operation SHALL discard any registered write; no write_enable pulse SHALL follow deassertion until a new acceptance.
REQ-020 Grants SHALL first be possible at the first rising edge after rst_n deasserts.

Verification
REQ-021 Single request: req_valid=01, req_addr[0]=5, req_data[0]=0xDEADBEEF -> req_ready=01 that cycle; next cycle write_enable=1, write_addr=5, write_data=0xDEADBEEF, grant_id=0.
REQ-022 Contention: both valid held for 4 cycles from reset -> grant order 0,1,0,1; write_enable high 4 consecutive cycles; conflict_count=4.
REQ-023 Hold: both valid with wb_hold=1 for 3 cycles -> req_ready=00 and write_enable=0 throughout, conflict_count unchanged; on release, requester at ptr granted first.
REQ-024 Zero skip: with SKIP_ZERO=1, requester 1 writes addr 0 -> accepted, write_enable stays 0, ptr becomes 0; a following addr 7 write is issued normally.
REQ-025 Saturation: CNT_WIDTH=4, 20 contended cycles -> conflict_count=15 and holds at 15.
REQ-026 Reset mid-write: rst_n pulled low in the cycle after acceptance -> write_enable drops to 0 asynchronously; all outputs 0 after deassertion; ptr=0.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: picks one of NUM_REQ register-file write
// requests per cycle and drives a single registered write port.
module writeback_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int REG_WIDTH  = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int SKIP_ZERO  = 0,
    parameter int CNT_WIDTH  = 16,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wb_hold,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*REG_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            write_enable,
    output logic [ADDR_WIDTH-1:0]           write_addr,
    output logic [REG_WIDTH-1:0]            write_data,
    output logic [ID_WIDTH-1:0]             grant_id,
    output logic [CNT_WIDTH-1:0]            conflict_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [ID_WIDTH-1:0]   ptr_r;
    logic [ID_WIDTH-1:0]   grant_idx_s;
    logic [ID_WIDTH-1:0]   next_ptr_s;
    logic                  found_s;
    logic                  allow_s;
    logic                  accept_s;
    logic                  skip_s;
    logic                  contended_s;
    logic [NUM_REQ-1:0]    grant_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [REG_WIDTH-1:0]  sel_data_s;

    logic                  write_enable_r;
    logic [ADDR_WIDTH-1:0] write_addr_r;
    logic [REG_WIDTH-1:0]  write_data_r;
    logic [ID_WIDTH-1:0]   grant_id_r;
    logic [CNT_WIDTH-1:0]  conflict_r;

    // Priority search: first valid requester at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = {ID_WIDTH{1'b0}};
        next_ptr_s  = ptr_r;
        sel_addr_s  = {ADDR_WIDTH{1'b0}};
        sel_data_s  = {REG_WIDTH{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found_s && (j == ((int'(ptr_r) + k) % NUM_REQ)) && req_valid[j]) begin
                    found_s     = 1'b1;
                    grant_idx_s = ID_WIDTH'(j);
                    next_ptr_s  = ID_WIDTH'((j + 1) % NUM_REQ);
                    sel_addr_s  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                    sel_data_s  = req_data[j*REG_WIDTH +: REG_WIDTH];
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // One-hot ready; rst_n gating keeps ready low during reset
    always_comb begin
        allow_s = found_s && !wb_hold && rst_n;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant_s[j] = allow_s && (grant_idx_s == ID_WIDTH'(j));
        end
    end

    assign req_ready   = grant_s;
    assign accept_s    = allow_s;
    assign skip_s      = (SKIP_ZERO != 32'sd0) && (sel_addr_s == {ADDR_WIDTH{1'b0}});
    assign contended_s = !wb_hold && ($countones(req_valid) > 32'sd1);

    // Round-robin pointer advances only on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {ID_WIDTH{1'b0}};
        end else if (accept_s) begin
            ptr_r <= next_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Single output stage: strobe for one cycle, payload held between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_enable_r <= 1'b0;
            write_addr_r   <= {ADDR_WIDTH{1'b0}};
            write_data_r   <= {REG_WIDTH{1'b0}};
            grant_id_r     <= {ID_WIDTH{1'b0}};
        end else if (accept_s) begin
            write_enable_r <= !skip_s;
            write_addr_r   <= sel_addr_s;
            write_data_r   <= sel_data_s;
            grant_id_r     <= grant_idx_s;
        end else begin
            write_enable_r <= 1'b0;
            write_addr_r   <= write_addr_r;
            write_data_r   <= write_data_r;
            grant_id_r     <= grant_id_r;
        end
    end

    // Saturating count of cycles with two or more competing requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_r <= {CNT_WIDTH{1'b0}};
        end else if (contended_s && (conflict_r != CNT_MAX)) begin
            conflict_r <= conflict_r + CNT_ONE;
        end else begin
            conflict_r <= conflict_r;
        end
    end

    assign write_enable   = write_enable_r;
    assign write_addr     = write_addr_r;
    assign write_data     = write_data_r;
    assign grant_id       = grant_id_r;
    assign conflict_count = conflict_r;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: a default instance and a SKIP_ZERO=1 / CNT_WIDTH=4
// instance share stimulus and are checked against a queue-based reference model.
module tb_writeback_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_hold;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;

    logic [1:0]  rdy_a, rdy_b;
    logic        we_a, we_b;
    logic [4:0]  wa_a, wa_b;
    logic [31:0] wd_a, wd_b;
    logic [0:0]  gid_a, gid_b;
    logic [15:0] cc_a;
    logic [3:0]  cc_b;

    int errors = 0;
    int checks = 0;

    // reference model state
    int          m_ptr;
    logic        m_we_a, m_we_b;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [0:0]  m_gid;
    int          m_cc_a, m_cc_b;

    logic [1:0]  exp_rdy, obs_rdy_a, obs_rdy_b;
    int          last_g;

    writeback_arbiter u_dut_a (
        .clk(clk), .rst_n(rst_n), .wb_hold(wb_hold),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(rdy_a), .write_enable(we_a), .write_addr(wa_a),
        .write_data(wd_a), .grant_id(gid_a), .conflict_count(cc_a)
    );

    writeback_arbiter #(.SKIP_ZERO(1), .CNT_WIDTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wb_hold(wb_hold),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(rdy_b), .write_enable(we_b), .write_addr(wa_b),
        .write_data(wd_b), .grant_id(gid_b), .conflict_count(cc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Priority list built from the current pointer; head of list wins.
    function automatic int pick();
        int order[$];
        order = {};
        for (int k = 0; k < 2; k++) begin
            if (req_valid[(m_ptr + k) % 2]) order.push_back((m_ptr + k) % 2);
        end
        return (order.size() > 0) ? order[0] : -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_we_a = 1'b0; m_we_b = 1'b0; m_addr = 5'd0;
        m_data = 32'd0; m_gid = 1'b0; m_cc_a = 0; m_cc_b = 0;
    endtask

    // Advance one clock: capture ready before the edge, update the model at the edge.
    task automatic step();
        int g;
        int nv;
        #1;
        g = (rst_n && !wb_hold) ? pick() : -1;
        exp_rdy = 2'b00;
        if (g >= 0) exp_rdy[g] = 1'b1;
        obs_rdy_a = rdy_a;
        obs_rdy_b = rdy_b;
        nv = $countones(req_valid);
        @(posedge clk);
        if (rst_n) begin
            if (g >= 0) begin
                m_ptr  = (g + 1) % 2;
                m_addr = req_addr[g*5 +: 5];
                m_data = req_data[g*32 +: 32];
                m_gid  = g[0:0];
                m_we_a = 1'b1;
                m_we_b = (m_addr != 5'd0);
            end else begin
                m_we_a = 1'b0;
                m_we_b = 1'b0;
            end
            if (!wb_hold && nv >= 2) begin
                m_cc_a = (m_cc_a < 65535) ? m_cc_a + 1 : 65535;
                m_cc_b = (m_cc_b < 15) ? m_cc_b + 1 : 15;
            end
        end
        last_g = g;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 2'b00; wb_hold = 1'b0;
        #3;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wb_hold = 1'b0; req_valid = 2'b11;
        req_addr = {5'd9, 5'd3}; req_data = {32'h1111_2222, 32'h3333_4444};
        #3;
        model_reset();
        checks++; if (rdy_a !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", rdy_a); end
        checks++; if (we_a !== 1'b0 || we_b !== 1'b0) begin errors++; $display("FAIL reset_we: got %b/%b expected 0", we_a, we_b); end
        checks++; if (wa_a !== 5'd0 || wd_a !== 32'd0 || gid_a !== 1'b0) begin errors++; $display("FAIL reset_payload: got %0h/%0h/%0h expected 0", wa_a, wd_a, gid_a); end
        checks++; if (cc_a !== 16'd0 || cc_b !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d/%0d expected 0", cc_a, cc_b); end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        req_valid = 2'b01; req_addr = {5'd0, 5'd5}; req_data = {32'd0, 32'hDEADBEEF};
        step();
        checks++; if (obs_rdy_a !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", obs_rdy_a); end
        checks++; if (we_a !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", we_a); end
        checks++; if (wa_a !== 5'd5 || wd_a !== 32'hDEADBEEF) begin errors++; $display("FAIL single_payload: got %0d/%h expected 5/deadbeef", wa_a, wd_a); end
        checks++; if (gid_a !== 1'b0) begin errors++; $display("FAIL single_gid: got %0d expected 0", gid_a); end
        req_valid = 2'b00;
        step();
        checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b expected 0", we_a); end
        checks++; if (wa_a !== 5'd5 || wd_a !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold: got %0d/%h expected 5/deadbeef", wa_a, wd_a); end
    endtask

    task automatic test_contention();
        do_reset();
        req_valid = 2'b11; req_addr = {5'd9, 5'd3}; req_data = {32'hBBBB_0001, 32'hAAAA_0000};
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (we_a !== 1'b1) begin errors++; $display("FAIL contend_we%0d: got %b expected 1", k, we_a); end
            checks++; if (gid_a !== 1'(k % 2)) begin errors++; $display("FAIL contend_gid%0d: got %0d expected %0d", k, gid_a, k % 2); end
        end
        checks++; if (cc_a !== 16'd4) begin errors++; $display("FAIL contend_count: got %0d expected 4", cc_a); end
        checks++; if (wa_a !== 5'd9 || wd_a !== 32'hBBBB_0001) begin errors++; $display("FAIL contend_payload: got %0d/%h expected 9/bbbb0001", wa_a, wd_a); end
    endtask

    task automatic test_hold();
        wb_hold = 1'b1; req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (obs_rdy_a !== 2'b00 || obs_rdy_b !== 2'b00) begin errors++; $display("FAIL hold_ready%0d: got %b/%b expected 00", k, obs_rdy_a, obs_rdy_b); end
            checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL hold_we%0d: got %b expected 0", k, we_a); end
            checks++; if (cc_a !== 16'(m_cc_a)) begin errors++; $display("FAIL hold_count%0d: got %0d expected %0d", k, cc_a, m_cc_a); end
        end
        wb_hold = 1'b0;
        step();
        checks++; if (obs_rdy_a !== exp_rdy || exp_rdy !== 2'b01) begin errors++; $display("FAIL hold_release: got %b expected 01 (model %b)", obs_rdy_a, exp_rdy); end
        checks++; if (we_a !== 1'b1 || gid_a !== 1'b0) begin errors++; $display("FAIL hold_release_we: got %b/%0d expected 1/0", we_a, gid_a); end
    endtask

    task automatic test_zero_skip();
        do_reset();
        req_valid = 2'b01; req_addr = {5'd0, 5'd2}; req_data = {32'hC0DE_0000, 32'h0000_0002};
        step();
        req_valid = 2'b10;
        step();
        checks++; if (obs_rdy_b !== 2'b10) begin errors++; $display("FAIL zskip_ready: got %b expected 10", obs_rdy_b); end
        checks++; if (we_b !== 1'b0) begin errors++; $display("FAIL zskip_we: got %b expected 0", we_b); end
        checks++; if (we_a !== 1'b1 || wa_a !== 5'd0) begin errors++; $display("FAIL zissue_we: got %b/%0d expected 1/0", we_a, wa_a); end
        checks++; if (wa_b !== 5'd0 || wd_b !== 32'hC0DE_0000 || gid_b !== 1'b1) begin errors++; $display("FAIL zskip_payload: got %0d/%h/%0d expected 0/c0de0000/1", wa_b, wd_b, gid_b); end
        req_valid = 2'b11; req_addr = {5'd0, 5'd7};
        step();
        checks++; if (obs_rdy_b !== 2'b01) begin errors++; $display("FAIL zskip_ptr: got %b expected 01", obs_rdy_b); end
        checks++; if (we_b !== 1'b1 || wa_b !== 5'd7) begin errors++; $display("FAIL zskip_next: got %b/%0d expected 1/7", we_b, wa_b); end
    endtask

    task automatic test_saturation();
        do_reset();
        req_valid = 2'b11; req_addr = {5'd1, 5'd2};
        for (int k = 0; k < 20; k++) step();
        checks++; if (cc_b !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d expected 15", cc_b); end
        checks++; if (cc_a !== 16'd20) begin errors++; $display("FAIL sat_wide: got %0d expected 20", cc_a); end
        for (int k = 0; k < 3; k++) step();
        checks++; if (cc_b !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", cc_b); end
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b01; req_addr = {5'd0, 5'd4}; req_data = {32'd0, 32'h0BAD_F00D};
        step();
        checks++; if (we_a !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %b expected 1", we_a); end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (we_a !== 1'b0 || we_b !== 1'b0) begin errors++; $display("FAIL rmid_async: got %b/%b expected 0", we_a, we_b); end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (we_a !== 1'b0 || wa_a !== 5'd0 || wd_a !== 32'd0 || gid_a !== 1'b0 || cc_a !== 16'd0) begin
            errors++; $display("FAIL rmid_after: got %b/%0d/%h/%0d/%0d expected all 0", we_a, wa_a, wd_a, gid_a, cc_a); end
        req_valid = 2'b11;
        step();
        checks++; if (obs_rdy_a !== 2'b01) begin errors++; $display("FAIL rmid_ptr: got %b expected 01", obs_rdy_a); end
    endtask

    task automatic test_random();
        int g;
        do_reset();
        last_g = -1;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || last_g == i) begin
                    req_valid[i] = ($urandom_range(0, 99) < 60);
                    req_addr[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                    req_data[i*32 +: 32] = $urandom;
                end
            end
            wb_hold = ($urandom_range(0, 99) < 20);
            step();
            g = last_g;
            checks++; if (obs_rdy_a !== exp_rdy || obs_rdy_b !== exp_rdy) begin errors++; $display("FAIL rnd_ready@%0d: got %b/%b expected %b", n, obs_rdy_a, obs_rdy_b, exp_rdy); end
            checks++; if (we_a !== m_we_a || we_b !== m_we_b) begin errors++; $display("FAIL rnd_we@%0d: got %b/%b expected %b/%b", n, we_a, we_b, m_we_a, m_we_b); end
            checks++; if (wa_a !== m_addr || wa_b !== m_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %0d/%0d expected %0d", n, wa_a, wa_b, m_addr); end
            checks++; if (wd_a !== m_data || wd_b !== m_data) begin errors++; $display("FAIL rnd_data@%0d: got %h/%h expected %h", n, wd_a, wd_b, m_data); end
            checks++; if (gid_a !== m_gid || gid_b !== m_gid) begin errors++; $display("FAIL rnd_gid@%0d: got %0d/%0d expected %0d (g=%0d)", n, gid_a, gid_b, m_gid, g); end
            checks++; if (cc_a !== 16'(m_cc_a) || cc_b !== 4'(m_cc_b)) begin errors++; $display("FAIL rnd_count@%0d: got %0d/%0d expected %0d/%0d", n, cc_a, cc_b, m_cc_a, m_cc_b); end
        end
        wb_hold = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wb_hold = 1'b0; req_valid = 2'b00; req_addr = 10'd0; req_data = 64'd0;
        last_g = -1;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_hold();
        test_zero_skip();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
